// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Purpose  : Round-robin arbiter and sequencer for the shared main bus mux.
//            Drives a one-hot (or all-zero) enable vector so that no two
//            sources ever drive the bus in the same cycle. Ownership ends
//            when the owner drops its request or when its burst limit runs
//            out while someone else is waiting. Every change of owner is
//            separated by TURN_CYC idle (all-zero) cycles.
// Ports    : clk_25mhz   in   1              system clock, rising edge
//            rst         in   1              asynchronous active-high reset
//            req         in   COUNT          per-source bus request (level)
//            enable      out  COUNT          registered mux enable, one-hot/0
//            owner       out  $clog2(COUNT)  current owner, valid when busy
//            busy        out  1              registered, equals |enable
//            grant_pulse out  1              strobe on first cycle of a grant
// Revision : 1.0  initial release
// ============================================================================
module bus_arbiter #(
    parameter int COUNT     = 4,
    parameter int MAX_BURST = 8,
    parameter int TURN_CYC  = 1
) (
    input  logic                     clk_25mhz,
    input  logic                     rst,
    input  logic [COUNT-1:0]         req,
    output logic [COUNT-1:0]         enable,
    output logic [$clog2(COUNT)-1:0] owner,
    output logic                     busy,
    output logic                     grant_pulse
);

    localparam int OW = $clog2(COUNT);
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int TW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

    localparam logic [BW-1:0] C_BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [TW-1:0] C_TURN_LAST  = TW'(TURN_CYC - 1);
    localparam logic [OW:0]   C_COUNT      = (OW + 1)'(COUNT);
    // Starting with the last index means source 0 is searched first.
    localparam logic [OW-1:0] C_RR_RESET   = OW'(COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    state_t          r_state;
    logic [OW-1:0]   r_rr_last;
    logic [BW-1:0]   r_burst_cnt;
    logic [TW-1:0]   r_turn_cnt;

    // ------------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------------
    state_t          w_state_nxt;
    logic [COUNT-1:0] w_enable_nxt;
    logic [OW-1:0]   w_owner_nxt;
    logic            w_busy_nxt;
    logic            w_grant_nxt;
    logic [OW-1:0]   w_rr_last_nxt;
    logic [BW-1:0]   w_burst_nxt;
    logic [TW-1:0]   w_turn_nxt;

    // Arbitration result
    logic [OW:0]     w_idx;
    logic            w_win_found;
    logic [OW-1:0]   w_win_idx;
    logic            w_grant_now;
    logic            w_others;

    // ------------------------------------------------------------------------
    // Round-robin search: start one past the last winner and wrap. The wider
    // index avoids overflow before the wrap-around subtraction.
    // ------------------------------------------------------------------------
    always_comb begin
        w_idx       = '0;
        w_win_found = 1'b0;
        w_win_idx   = '0;
        for (int k = 1; k <= COUNT; k++) begin
            w_idx = {1'b0, r_rr_last} + (OW + 1)'(k);
            if (w_idx >= C_COUNT) begin
                w_idx = w_idx - C_COUNT;
            end
            if (!w_win_found && req[w_idx[OW-1:0]]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_idx[OW-1:0];
            end
        end
    end

    // While granted, enable is the owner's one-hot mask, so masking req with
    // it leaves only the requests of other sources.
    assign w_others = |(req & ~enable);

    // ------------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_enable_nxt  = enable;
        w_owner_nxt   = owner;
        w_grant_nxt   = 1'b0;
        w_rr_last_nxt = r_rr_last;
        w_burst_nxt   = r_burst_cnt;
        w_turn_nxt    = r_turn_cnt;
        w_grant_now   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_enable_nxt = '0;
                if (w_win_found) begin
                    w_grant_now = 1'b1;
                end
            end

            ST_GRANT: begin
                if (!req[owner]) begin
                    // Owner let go voluntarily.
                    w_state_nxt  = ST_TURN;
                    w_enable_nxt = '0;
                    w_turn_nxt   = '0;
                end else if (r_burst_cnt == C_BURST_LAST) begin
                    if (w_others) begin
                        // Burst used up and someone is waiting: force release.
                        w_state_nxt  = ST_TURN;
                        w_enable_nxt = '0;
                        w_turn_nxt   = '0;
                    end else begin
                        // Nobody waiting: keep the bus, start a fresh burst.
                        w_burst_nxt = '0;
                    end
                end else begin
                    w_burst_nxt = r_burst_cnt + BW'(1);
                end
            end

            ST_TURN: begin
                w_enable_nxt = '0;
                if (r_turn_cnt == C_TURN_LAST) begin
                    if (w_win_found) begin
                        w_grant_now = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_turn_nxt = r_turn_cnt + TW'(1);
                end
            end

            default: begin
                w_state_nxt  = ST_IDLE;
                w_enable_nxt = '0;
            end
        endcase

        // A new grant looks the same whether it comes from IDLE or TURN.
        if (w_grant_now) begin
            w_state_nxt   = ST_GRANT;
            w_enable_nxt  = COUNT'(1) << w_win_idx;
            w_owner_nxt   = w_win_idx;
            w_rr_last_nxt = w_win_idx;
            w_burst_nxt   = '0;
            w_grant_nxt   = 1'b1;
        end

        w_busy_nxt = |w_enable_nxt;
    end

    // ------------------------------------------------------------------------
    // State register. Reset is asynchronous so enable drops immediately even
    // in the middle of a grant.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_25mhz or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            enable      <= '0;
            owner       <= '0;
            busy        <= 1'b0;
            grant_pulse <= 1'b0;
            r_rr_last   <= C_RR_RESET;
            r_burst_cnt <= '0;
            r_turn_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            enable      <= w_enable_nxt;
            owner       <= w_owner_nxt;
            busy        <= w_busy_nxt;
            grant_pulse <= w_grant_nxt;
            r_rr_last   <= w_rr_last_nxt;
            r_burst_cnt <= w_burst_nxt;
            r_turn_cnt  <= w_turn_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Simulation invariants
    // ------------------------------------------------------------------------
    a_enable_onehot0 : assert property (
        @(posedge clk_25mhz) disable iff (rst) $onehot0(enable));

    a_busy_matches : assert property (
        @(posedge clk_25mhz) disable iff (rst) busy == (|enable));

    // Two consecutive non-zero enables must belong to the same owner; any
    // change of owner has to pass through idle cycles.
    a_no_direct_switch : assert property (
        @(posedge clk_25mhz) disable iff (rst)
        ((enable != '0) && ($past(enable) != '0)) |-> (enable == $past(enable)));

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter
// Purpose  : Directed self-checking bench for bus_arbiter. Instance a uses the
//            default build (COUNT=4, MAX_BURST=8, TURN_CYC=1); instance b uses
//            MAX_BURST=2, TURN_CYC=3 for the long-turnaround pattern.
// Revision : 1.0  initial release
// ============================================================================
module tb_bus_arbiter;

    logic       clk_25mhz = 1'b0;
    logic       rst       = 1'b1;
    logic [3:0] req_a     = 4'b0000;
    logic [3:0] req_b     = 4'b0000;
    logic [3:0] en_a, en_b;
    logic [1:0] own_a, own_b;
    logic       busy_a, busy_b;
    logic       gp_a, gp_b;

    int checks   = 0;
    int failures = 0;

    always #20 clk_25mhz = ~clk_25mhz;

    bus_arbiter #(.COUNT(4), .MAX_BURST(8), .TURN_CYC(1)) dut_a (
        .clk_25mhz  (clk_25mhz),
        .rst        (rst),
        .req        (req_a),
        .enable     (en_a),
        .owner      (own_a),
        .busy       (busy_a),
        .grant_pulse(gp_a)
    );

    bus_arbiter #(.COUNT(4), .MAX_BURST(2), .TURN_CYC(3)) dut_b (
        .clk_25mhz  (clk_25mhz),
        .rst        (rst),
        .req        (req_b),
        .enable     (en_b),
        .owner      (own_b),
        .busy       (busy_b),
        .grant_pulse(gp_b)
    );

    // Advance one clock; outputs are observed 1 ns after the rising edge and
    // inputs changed there are sampled by the following edge.
    task automatic step();
        @(posedge clk_25mhz);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        req_a = 4'b0000;
        req_b = 4'b0000;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (en_a !== 4'b0000) begin
            failures++; $display("FAIL reset_enable got=%b exp=0000", en_a);
        end
        checks++;
        if (own_a !== 2'd0) begin
            failures++; $display("FAIL reset_owner got=%0d exp=0", own_a);
        end
        checks++;
        if (busy_a !== 1'b0 || gp_a !== 1'b0) begin
            failures++; $display("FAIL reset_busy_gp got=%b%b exp=00", busy_a, gp_a);
        end
        checks++;
        if (en_b !== 4'b0000) begin
            failures++; $display("FAIL reset_enable_b got=%b exp=0000", en_b);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (en_a !== 4'b0000 || busy_a !== 1'b0) begin
                failures++; $display("FAIL idle_no_req got=%b/%b exp=0000/0", en_a, busy_a);
            end
        end
    endtask

    task automatic test_single_grant();
        do_reset();
        req_a = 4'b0001;
        checks++;
        if (en_a !== 4'b0000) begin
            failures++; $display("FAIL single_latency got=%b exp=0000", en_a);
        end
        step();
        checks++;
        if (en_a !== 4'b0001 || gp_a !== 1'b1 || own_a !== 2'd0 || busy_a !== 1'b1) begin
            failures++;
            $display("FAIL single_grant got en=%b gp=%b own=%0d busy=%b exp en=0001 gp=1 own=0 busy=1",
                     en_a, gp_a, own_a, busy_a);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (en_a !== 4'b0001 || gp_a !== 1'b0 || busy_a !== 1'b1) begin
                failures++;
                $display("FAIL single_hold got en=%b gp=%b busy=%b exp en=0001 gp=0 busy=1",
                         en_a, gp_a, busy_a);
            end
        end
        req_a = 4'b0000;
        step();
        checks++;
        if (en_a !== 4'b0000 || busy_a !== 1'b0 || own_a !== 2'd0) begin
            failures++;
            $display("FAIL single_release got en=%b busy=%b own=%0d exp en=0000 busy=0 own=0",
                     en_a, busy_a, own_a);
        end
        step();
        checks++;
        if (en_a !== 4'b0000) begin
            failures++; $display("FAIL single_idle got=%b exp=0000", en_a);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_en;
        int         exp_own;
        do_reset();
        req_a = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            exp_own = g % 4;
            exp_en  = 4'b0001 << exp_own;
            for (int c = 0; c < 8; c++) begin
                step();
                checks++;
                if (en_a !== exp_en || gp_a !== (c == 0)) begin
                    failures++;
                    $display("FAIL rr_grant g=%0d c=%0d got en=%b gp=%b exp en=%b gp=%0d",
                             g, c, en_a, gp_a, exp_en, (c == 0));
                end
                if (c == 0) begin
                    checks++;
                    if (own_a !== exp_own[1:0]) begin
                        failures++; $display("FAIL rr_owner g=%0d got=%0d exp=%0d", g, own_a, exp_own);
                    end
                end
            end
            step();
            checks++;
            if (en_a !== 4'b0000 || busy_a !== 1'b0) begin
                failures++;
                $display("FAIL rr_turn g=%0d got en=%b busy=%b exp en=0000 busy=0", g, en_a, busy_a);
            end
        end
        req_a = 4'b0000;
        step();
    endtask

    task automatic test_no_contention();
        int pulses = 0;
        do_reset();
        req_a = 4'b0100;
        for (int c = 0; c < 20; c++) begin
            step();
            if (gp_a === 1'b1) pulses++;
            checks++;
            if (en_a !== 4'b0100 || own_a !== 2'd2) begin
                failures++;
                $display("FAIL solo_hold c=%0d got en=%b own=%0d exp en=0100 own=2", c, en_a, own_a);
            end
        end
        checks++;
        if (pulses != 1) begin
            failures++; $display("FAIL solo_pulses got=%0d exp=1", pulses);
        end
        req_a = 4'b0000;
        step();
        checks++;
        if (en_a !== 4'b0000) begin
            failures++; $display("FAIL solo_release got=%b exp=0000", en_a);
        end
        step();
    endtask

    task automatic test_release_rotation();
        do_reset();
        req_a = 4'b0010;
        step();
        checks++;
        if (en_a !== 4'b0010 || own_a !== 2'd1) begin
            failures++; $display("FAIL rot_first got en=%b own=%0d exp en=0010 own=1", en_a, own_a);
        end
        req_a = 4'b1011;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if (en_a !== 4'b0010 || gp_a !== 1'b0) begin
                failures++; $display("FAIL rot_ignore got en=%b gp=%b exp en=0010 gp=0", en_a, gp_a);
            end
        end
        req_a = 4'b1001;
        step();
        checks++;
        if (en_a !== 4'b0000 || busy_a !== 1'b0 || own_a !== 2'd1) begin
            failures++;
            $display("FAIL rot_turn got en=%b busy=%b own=%0d exp en=0000 busy=0 own=1",
                     en_a, busy_a, own_a);
        end
        step();
        checks++;
        if (en_a !== 4'b1000 || own_a !== 2'd3 || gp_a !== 1'b1) begin
            failures++;
            $display("FAIL rot_next got en=%b own=%0d gp=%b exp en=1000 own=3 gp=1", en_a, own_a, gp_a);
        end
        req_a = 4'b0000;
        step();
        step();
    endtask

    task automatic test_async_reset();
        do_reset();
        req_a = 4'b0100;
        step();
        step();
        checks++;
        if (en_a !== 4'b0100) begin
            failures++; $display("FAIL ares_pre got=%b exp=0100", en_a);
        end
        #5;
        rst = 1'b1;
        #1;
        checks++;
        if (en_a !== 4'b0000 || busy_a !== 1'b0) begin
            failures++; $display("FAIL ares_immediate got en=%b busy=%b exp en=0000 busy=0", en_a, busy_a);
        end
        req_a = 4'b1111;
        step();
        checks++;
        if (en_a !== 4'b0000) begin
            failures++; $display("FAIL ares_held got=%b exp=0000", en_a);
        end
        rst = 1'b0;
        step();
        checks++;
        if (en_a !== 4'b0001 || own_a !== 2'd0 || gp_a !== 1'b1) begin
            failures++;
            $display("FAIL ares_first got en=%b own=%0d gp=%b exp en=0001 own=0 gp=1", en_a, own_a, gp_a);
        end
        req_a = 4'b0000;
        step();
        step();
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_en;
        do_reset();
        req_b = 4'b0011;
        for (int g = 0; g < 4; g++) begin
            exp_en = 4'b0001 << (g % 2);
            for (int c = 0; c < 2; c++) begin
                step();
                checks++;
                if (en_b !== exp_en || gp_b !== (c == 0) || !$onehot0(en_b)) begin
                    failures++;
                    $display("FAIL b2b_on g=%0d c=%0d got en=%b gp=%b exp en=%b gp=%0d",
                             g, c, en_b, gp_b, exp_en, (c == 0));
                end
            end
            for (int c = 0; c < 3; c++) begin
                step();
                checks++;
                if (en_b !== 4'b0000 || busy_b !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_off g=%0d c=%0d got en=%b busy=%b exp en=0000 busy=0",
                             g, c, en_b, busy_b);
                end
            end
        end
        req_b = 4'b0000;
        step();
    endtask

    initial begin
        test_reset();
        test_single_grant();
        test_round_robin();
        test_no_contention();
        test_release_rotation();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
